// File: rtl/lsu_ctrl_if.sv
// Issue, memory-bus and writeback signal bundle for the load/store unit.
// master = issuing pipeline / memory model side, slave = lsu_ctrl side.
interface lsu_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  op_valid;
    logic                  op_ready;
    logic                  op_store;
    logic [2:0]            op_funct3;
    logic [31:0]           rs1_val;
    logic [31:0]           rs2_val;
    logic [31:0]           imm;
    logic [REG_ADDR_W-1:0] rd;

    logic                  mem_req;
    logic                  mem_gnt;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [31:0]           wb_data;
    logic                  stall_pc;
    logic                  misalign_exc;

    modport slave (
        input  op_valid, op_store, op_funct3, rs1_val, rs2_val, imm, rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output op_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output wb_valid, wb_rd, wb_data, stall_pc, misalign_exc
    );

    modport master (
        output op_valid, op_store, op_funct3, rs1_val, rs2_val, imm, rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  op_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  wb_valid, wb_rd, wb_data, stall_pc, misalign_exc
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: IDLE -> REQ -> RESP -> (WB) -> IDLE.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them down.
module lsu_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    lsu_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RESP = 2'd2, ST_WB = 2'd3} state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Select the addressed lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: load_extend = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: load_extend = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    state_t                state_r, state_s;
    logic                  accept_s, misalign_s, go_s, uns_s;
    logic [1:0]            size_s;
    logic [31:0]           ea_s, ea_al_s, wdata_s;
    logic [3:0]            be_s;

    logic                  op_ready_r, stall_pc_r, mem_req_r, mem_we_r, misalign_exc_r;
    logic [ADDR_W-1:0]     mem_addr_r;
    logic [31:0]           mem_wdata_r, wb_data_r;
    logic [3:0]            mem_be_r;
    logic                  wb_valid_r, store_r, uns_r;
    logic [1:0]            size_r, off_r;
    logic [REG_ADDR_W-1:0] rd_r, wb_rd_r;

    // Decode the offered op: effective address, access size, lanes and store data.
    always_comb begin
        ea_s     = bus.rs1_val + bus.imm;
        accept_s = bus.op_valid & op_ready_r;
        case (bus.op_funct3)
            3'b000:  size_s = SZ_BYTE;
            3'b001:  size_s = SZ_HALF;
            3'b100:  size_s = bus.op_store ? SZ_WORD : SZ_BYTE;
            3'b101:  size_s = bus.op_store ? SZ_WORD : SZ_HALF;
            default: size_s = SZ_WORD;
        endcase
        uns_s = ~bus.op_store & bus.op_funct3[2] & (size_s != SZ_WORD);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = ((size_s == SZ_HALF) & ea_s[0]) | ((size_s == SZ_WORD) & (ea_s[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        go_s = accept_s & ~misalign_s;
        case (size_s)
            SZ_BYTE: begin
                ea_al_s = ea_s;
                be_s    = 4'b0001 << ea_s[1:0];
                wdata_s = {4{bus.rs2_val[7:0]}};
            end
            SZ_HALF: begin
                ea_al_s = {ea_s[31:1], 1'b0};
                be_s    = 4'b0011 << {ea_s[1], 1'b0};
                wdata_s = {2{bus.rs2_val[15:0]}};
            end
            default: begin
                ea_al_s = {ea_s[31:2], 2'b00};
                be_s    = 4'b1111;
                wdata_s = bus.rs2_val;
            end
        endcase
        if (!bus.op_store) begin
            be_s    = 4'b1111;
            wdata_s = 32'h00000000;
        end else begin
            be_s    = be_s;
        end
    end

    // Next-state logic; bus handshakes only matter in their own state.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (go_s)           state_s = ST_REQ;  else state_s = ST_IDLE;
            ST_REQ:  if (bus.mem_gnt)    state_s = ST_RESP; else state_s = ST_REQ;
            ST_RESP: if (bus.mem_rvalid) state_s = store_r ? ST_IDLE : ST_WB;
                     else                state_s = ST_RESP;
            ST_WB:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r    <= ST_IDLE;
            op_ready_r <= 1'b1;
            stall_pc_r <= 1'b0;
            mem_req_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            op_ready_r <= (state_s == ST_IDLE);
            stall_pc_r <= (state_s != ST_IDLE);
            mem_req_r  <= (state_s == ST_REQ);
        end
    end

    // Capture op fields at acceptance; build load writeback on the read response.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mem_we_r       <= 1'b0;
            mem_addr_r     <= '0;
            mem_wdata_r    <= 32'h00000000;
            mem_be_r       <= 4'b0000;
            store_r        <= 1'b0;
            uns_r          <= 1'b0;
            size_r         <= SZ_WORD;
            off_r          <= 2'b00;
            rd_r           <= '0;
            misalign_exc_r <= 1'b0;
            wb_valid_r     <= 1'b0;
            wb_rd_r        <= '0;
            wb_data_r      <= 32'h00000000;
        end else begin
            misalign_exc_r <= accept_s & misalign_s;
            wb_valid_r     <= 1'b0;
            if (go_s) begin
                mem_we_r    <= bus.op_store;
                mem_addr_r  <= {ea_al_s[ADDR_W-1:2], 2'b00};
                mem_wdata_r <= wdata_s;
                mem_be_r    <= be_s;
                store_r     <= bus.op_store;
                uns_r       <= uns_s;
                size_r      <= size_s;
                off_r       <= ea_al_s[1:0];
                rd_r        <= bus.rd;
            end
            if ((state_r == ST_RESP) && bus.mem_rvalid && !store_r) begin
                wb_valid_r <= (rd_r != '0);
                wb_rd_r    <= rd_r;
                wb_data_r  <= load_extend(bus.mem_rdata, off_r, size_r, uns_r);
            end
        end
    end

    assign bus.op_ready     = op_ready_r;
    assign bus.stall_pc     = stall_pc_r;
    assign bus.mem_req      = mem_req_r;
    assign bus.mem_we       = mem_we_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_wdata    = mem_wdata_r;
    assign bus.mem_be       = mem_be_r;
    assign bus.misalign_exc = misalign_exc_r;
    assign bus.wb_valid     = wb_valid_r;
    assign bus.wb_rd        = wb_rd_r;
    assign bus.wb_data      = wb_data_r;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed corner cases plus random ops against an arithmetic model.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    lsu_ctrl_if #(.ADDR_W(32), .REG_ADDR_W(5)) bus ();
    lsu_ctrl #(.ADDR_W(32), .REG_ADDR_W(5)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(bus.op_ready), 32'd1);
        check_eq({tag, "_stall"}, 32'(bus.stall_pc), 32'd0);
        check_eq({tag, "_req"},   32'(bus.mem_req),  32'd0);
        check_eq({tag, "_wbv"},   32'(bus.wb_valid), 32'd0);
    endtask

    // One load/store with given bus delays; expectations come from byte-level arithmetic.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [4:0] r, input int gd, input int rvd,
                         input logic [31:0] rdat, input logic noise);
        int          sz;
        bit          uns, mis;
        logic [31:0] ea, al, wd_e, ld_e;
        logic [3:0]  be_e;
        longint      sh, v, be_l;
        sz  = (f3 == 3'd0 || (f3 == 3'd4 && !st)) ? 1 : (f3 == 3'd1 || (f3 == 3'd5 && !st)) ? 2 : 4;
        uns = !st && (f3 == 3'd4 || f3 == 3'd5);
        ea  = a + im;
        al  = ea - (ea % sz);
        mis = (ea % sz) != 0;
        be_l = ((longint'(1) << sz) - 1) << (al % 4);
        be_e = st ? be_l[3:0] : 4'hF;
        wd_e = (sz == 1) ? {24'h0, b[7:0]} * 32'h01010101 : (sz == 2) ? {16'h0, b[15:0]} * 32'h00010001 : b;
        sh   = longint'(rdat) >> (8 * (al % 4));
        v    = sh % (longint'(1) << (8 * sz));
        if (!uns && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        ld_e = v[31:0];

        @(negedge clk);
        check_eq("ready_before", 32'(bus.op_ready), 32'd1);
        bus.op_valid = 1'b1; bus.op_store = st; bus.op_funct3 = f3;
        bus.rs1_val = a; bus.rs2_val = b; bus.imm = im; bus.rd = r;
        @(negedge clk);
        bus.op_valid = 1'b0;
        if (mis && TRAP) begin
            check_eq("misalign_pulse", 32'(bus.misalign_exc), 32'd1);
            check_idle_outputs("trap");
            @(negedge clk);
            check_eq("misalign_end", 32'(bus.misalign_exc), 32'd0);
            check_idle_outputs("trap2");
            return;
        end
        check_eq("misalign_none", 32'(bus.misalign_exc), 32'd0);
        for (int i = 0; i <= gd; i++) begin
            check_eq("req_high", 32'(bus.mem_req), 32'd1);
            check_eq("req_addr", bus.mem_addr, al & 32'hFFFFFFFC);
            check_eq("req_we",   32'(bus.mem_we), 32'(st));
            check_eq("req_be",   32'(bus.mem_be), 32'(be_e));
            if (st) check_eq("req_wdata", bus.mem_wdata, wd_e);
            check_eq("req_stall", 32'(bus.stall_pc), 32'd1);
            check_eq("req_ready", 32'(bus.op_ready), 32'd0);
            check_eq("req_wbv",   32'(bus.wb_valid), 32'd0);
            if (i == gd) begin
                bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0; bus.op_valid = 1'b0;
            end else begin
                bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'($urandom % 2);
                if (noise) begin bus.op_valid = 1'b1; bus.rs1_val = $urandom; end
            end
            @(negedge clk);
        end
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.op_valid = 1'b0;
        for (int i = 0; i <= rvd; i++) begin
            check_eq("resp_req",   32'(bus.mem_req), 32'd0);
            check_eq("resp_stall", 32'(bus.stall_pc), 32'd1);
            check_eq("resp_ready", 32'(bus.op_ready), 32'd0);
            check_eq("resp_wbv",   32'(bus.wb_valid), 32'd0);
            if (i == rvd) begin
                bus.mem_rvalid = 1'b1; bus.mem_rdata = rdat; bus.mem_gnt = 1'b0; bus.op_valid = 1'b0;
            end else begin
                bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom; bus.mem_gnt = 1'($urandom % 2);
                if (noise) begin bus.op_valid = 1'b1; bus.rs1_val = $urandom; end
            end
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b0; bus.op_valid = 1'b0;
        if (!st) begin
            check_eq("wb_valid", 32'(bus.wb_valid), 32'(r != 5'd0));
            if (r != 5'd0) begin
                check_eq("wb_rd",   32'(bus.wb_rd), 32'(r));
                check_eq("wb_data", bus.wb_data, ld_e);
            end
            check_eq("wb_stall", 32'(bus.stall_pc), 32'd1);
            check_eq("wb_ready", 32'(bus.op_ready), 32'd0);
            @(negedge clk);
        end
        check_idle_outputs("done");
    endtask

    initial begin
        bus.op_valid = 1'b0; bus.op_store = 1'b0; bus.op_funct3 = 3'd0;
        bus.rs1_val = 32'h0; bus.rs2_val = 32'h0; bus.imm = 32'h0; bus.rd = 5'd0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst");
        check_eq("rst_addr",  bus.mem_addr, 32'h0);
        check_eq("rst_wdata", bus.mem_wdata, 32'h0);
        check_eq("rst_be",    32'(bus.mem_be), 32'h0);
        check_eq("rst_we",    32'(bus.mem_we), 32'h0);
        check_eq("rst_wbrd",  32'(bus.wb_rd), 32'h0);
        check_eq("rst_wbdat", bus.wb_data, 32'h0);
        check_eq("rst_mis",   32'(bus.misalign_exc), 32'h0);
        rst = 1'b1;

        do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h4, 5'd7, 0, 0, 32'hDEADBEEF, 1'b0);
        do_op(1'b0, 3'b000, 32'h200, 32'h0, 32'h3, 5'd3, 0, 0, 32'h80FFFFFF, 1'b0);
        do_op(1'b0, 3'b100, 32'h200, 32'h0, 32'h3, 5'd3, 1, 0, 32'h80FFFFFF, 1'b0);
        do_op(1'b1, 3'b001, 32'h300, 32'h1234ABCD, 32'h2, 5'd9, 0, 0, 32'h0, 1'b0);
        do_op(1'b0, 3'b010, 32'h400, 32'h0, 32'h8, 5'd12, 3, 2, 32'h5A5AA5A5, 1'b1);
        do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'h2, 5'd5, 0, 0, 32'hCAFEF00D, 1'b0);
        do_op(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'h3, 5'd0, 0, 1, 32'h8001_7FFF, 1'b0);

        // Reset while waiting for read data; a late rvalid must not write back.
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_store = 1'b0; bus.op_funct3 = 3'b010;
        bus.rs1_val = 32'h500; bus.imm = 32'h0; bus.rd = 5'd4;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check_eq("pre_rst_stall", 32'(bus.stall_pc), 32'd1);
        rst = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        check_eq("async_rst_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11223344;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check_idle_outputs("post_rst");
        @(negedge clk);
        check_idle_outputs("post_rst2");

        for (int k = 0; k < 60; k++) begin
            do_op(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, 32'($urandom % 64),
                  5'($urandom % 32), int'($urandom % 4), int'($urandom % 4), $urandom, 1'($urandom % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
